// File: rtl/nnrv_pkg.sv
// Shared constants and helpers for the nnrv memory-access stage.
// Memory-op encoding, FSM state type and byte-strobe patterns.
package nnrv_pkg;

    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LB   = 4'd1;
    localparam logic [3:0] MEM_OP_LH   = 4'd2;
    localparam logic [3:0] MEM_OP_LW   = 4'd3;
    localparam logic [3:0] MEM_OP_LBU  = 4'd4;
    localparam logic [3:0] MEM_OP_LHU  = 4'd5;
    localparam logic [3:0] MEM_OP_SB   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SW   = 4'd8;

    localparam logic [3:0] WSTRB_NONE    = 4'b0000;
    localparam logic [3:0] WSTRB_BYTE0   = 4'b0001;
    localparam logic [3:0] WSTRB_LO_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_HI_HALF = 4'b1100;
    localparam logic [3:0] WSTRB_ALL     = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LH) || (op == MEM_OP_LW) ||
               (op == MEM_OP_LBU) || (op == MEM_OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic half;
        logic word;
        half = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
        word = (op == MEM_OP_LW) || (op == MEM_OP_SW);
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/nnrv_load_align.sv
// Extracts the addressed byte/half/word from a bus read word and extends it
// to XLEN according to the load flavour.
module nnrv_load_align
    import nnrv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [3:0]      i_op,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_op)
            MEM_OP_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            MEM_OP_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
            MEM_OP_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
            MEM_OP_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
            default:    o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/nnrv_mem.sv
// Memory-access stage: passes ALU results through, runs byte/half/word loads
// and stores over a req/ack bus, and reports misalignment or bus timeout.
module nnrv_mem
    import nnrv_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_exec_rd_en,
    input  logic [4:0]      i_exec_rd,
    input  logic [XLEN-1:0] i_exec_rd_reg,
    input  logic [3:0]      i_exec_mem_op,
    input  logic [XLEN-1:0] i_exec_store_data,
    output logic            o_exec_stall,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_wstrb,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_wb_rd_en,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_rd_data,
    output logic            o_mem_fault,
    output logic [XLEN-1:0] o_fault_addr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_req, w_req_nxt;
    logic              r_we, w_we_nxt;
    logic [XLEN-1:0]   r_addr_bus, w_addr_bus_nxt;
    logic [XLEN-1:0]   r_wdata, w_wdata_nxt;
    logic [3:0]        r_wstrb, w_wstrb_nxt;
    logic              r_wb_en, w_wb_en_nxt;
    logic [4:0]        r_wb_rd, w_wb_rd_nxt;
    logic [XLEN-1:0]   r_wb_data, w_wb_data_nxt;
    logic              r_fault, w_fault_nxt;
    logic [XLEN-1:0]   r_fault_addr, w_fault_addr_nxt;
    logic              r_lat_rd_en, w_lat_rd_en_nxt;
    logic [4:0]        r_lat_rd, w_lat_rd_nxt;
    logic [3:0]        r_lat_op, w_lat_op_nxt;
    logic [XLEN-1:0]   r_lat_addr, w_lat_addr_nxt;

    logic              w_is_mem;
    logic [XLEN-1:0]   w_lane_data;
    logic [3:0]        w_lane_strb;
    logic [XLEN-1:0]   w_load_data;

    nnrv_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_rdata   (i_dmem_rdata),
        .i_addr_lo (r_lat_addr[1:0]),
        .i_op      (r_lat_op),
        .o_data    (w_load_data)
    );

    // Store lane replication and strobes; loads never assert strobes.
    always_comb begin
        w_is_mem    = is_load(i_exec_mem_op) || is_store(i_exec_mem_op);
        w_lane_data = i_exec_store_data;
        w_lane_strb = WSTRB_NONE;
        case (i_exec_mem_op)
            MEM_OP_SB: begin
                w_lane_data = {(XLEN/8){i_exec_store_data[7:0]}};
                w_lane_strb = WSTRB_BYTE0 << i_exec_rd_reg[1:0];
            end
            MEM_OP_SH: begin
                w_lane_data = {(XLEN/16){i_exec_store_data[15:0]}};
                w_lane_strb = i_exec_rd_reg[1] ? WSTRB_HI_HALF : WSTRB_LO_HALF;
            end
            MEM_OP_SW: w_lane_strb = WSTRB_ALL;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_req_nxt        = r_req;
        w_we_nxt         = r_we;
        w_addr_bus_nxt   = r_addr_bus;
        w_wdata_nxt      = r_wdata;
        w_wstrb_nxt      = r_wstrb;
        w_wb_en_nxt      = 1'b0;
        w_wb_rd_nxt      = r_wb_rd;
        w_wb_data_nxt    = r_wb_data;
        w_fault_nxt      = 1'b0;
        w_fault_addr_nxt = r_fault_addr;
        w_lat_rd_en_nxt  = r_lat_rd_en;
        w_lat_rd_nxt     = r_lat_rd;
        w_lat_op_nxt     = r_lat_op;
        w_lat_addr_nxt   = r_lat_addr;

        case (r_state)
            ST_IDLE: begin
                if (w_is_mem) begin
                    if (is_misaligned(i_exec_mem_op, i_exec_rd_reg[1:0])) begin
                        w_fault_nxt      = 1'b1;
                        w_fault_addr_nxt = i_exec_rd_reg;
                    end else begin
                        w_lat_rd_en_nxt = i_exec_rd_en;
                        w_lat_rd_nxt    = i_exec_rd;
                        w_lat_op_nxt    = i_exec_mem_op;
                        w_lat_addr_nxt  = i_exec_rd_reg;
                        w_req_nxt       = 1'b1;
                        w_we_nxt        = is_store(i_exec_mem_op);
                        w_addr_bus_nxt  = {i_exec_rd_reg[XLEN-1:2], 2'b00};
                        w_wdata_nxt     = w_lane_data;
                        w_wstrb_nxt     = w_lane_strb;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = ST_BUSY;
                    end
                end else if (i_exec_rd_en && (i_exec_rd != 5'd0)) begin
                    w_wb_en_nxt   = 1'b1;
                    w_wb_rd_nxt   = i_exec_rd;
                    w_wb_data_nxt = i_exec_rd_reg;
                end
            end
            ST_BUSY: begin
                // Ack takes priority over a timeout landing on the same cycle.
                if (i_dmem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (is_load(r_lat_op) && r_lat_rd_en && (r_lat_rd != 5'd0)) begin
                        w_wb_en_nxt   = 1'b1;
                        w_wb_rd_nxt   = r_lat_rd;
                        w_wb_data_nxt = w_load_data;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_req_nxt        = 1'b0;
                    w_fault_nxt      = 1'b1;
                    w_fault_addr_nxt = r_lat_addr;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr_bus   <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_wb_en      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
            r_lat_rd_en  <= 1'b0;
            r_lat_rd     <= '0;
            r_lat_op     <= MEM_OP_NONE;
            r_lat_addr   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req        <= w_req_nxt;
            r_we         <= w_we_nxt;
            r_addr_bus   <= w_addr_bus_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wstrb      <= w_wstrb_nxt;
            r_wb_en      <= w_wb_en_nxt;
            r_wb_rd      <= w_wb_rd_nxt;
            r_wb_data    <= w_wb_data_nxt;
            r_fault      <= w_fault_nxt;
            r_fault_addr <= w_fault_addr_nxt;
            r_lat_rd_en  <= w_lat_rd_en_nxt;
            r_lat_rd     <= w_lat_rd_nxt;
            r_lat_op     <= w_lat_op_nxt;
            r_lat_addr   <= w_lat_addr_nxt;
        end
    end

    assign o_exec_stall = (r_state == ST_BUSY);
    assign o_dmem_req   = r_req;
    assign o_dmem_we    = r_we;
    assign o_dmem_addr  = r_addr_bus;
    assign o_dmem_wdata = r_wdata;
    assign o_dmem_wstrb = r_wstrb;
    assign o_wb_rd_en   = r_wb_en;
    assign o_wb_rd      = r_wb_rd;
    assign o_wb_rd_data = r_wb_data;
    assign o_mem_fault  = r_fault;
    assign o_fault_addr = r_fault_addr;

endmodule

// File: tb/tb_nnrv_mem.sv
// Directed self-checking bench for the nnrv_mem memory-access stage.
module tb_nnrv_mem;

    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exec_rd_en = 1'b0;
    logic [4:0]  exec_rd = '0;
    logic [31:0] exec_rd_reg = '0;
    logic [3:0]  exec_mem_op = '0;
    logic [31:0] exec_store_data = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        exec_stall, dmem_req, dmem_we, wb_rd_en, mem_fault;
    logic [31:0] dmem_addr, dmem_wdata, wb_rd_data, fault_addr;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nnrv_mem #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_exec_rd_en      (exec_rd_en),
        .i_exec_rd         (exec_rd),
        .i_exec_rd_reg     (exec_rd_reg),
        .i_exec_mem_op     (exec_mem_op),
        .i_exec_store_data (exec_store_data),
        .o_exec_stall      (exec_stall),
        .o_dmem_req        (dmem_req),
        .o_dmem_we         (dmem_we),
        .o_dmem_addr       (dmem_addr),
        .o_dmem_wdata      (dmem_wdata),
        .o_dmem_wstrb      (dmem_wstrb),
        .i_dmem_ack        (dmem_ack),
        .i_dmem_rdata      (dmem_rdata),
        .o_wb_rd_en        (wb_rd_en),
        .o_wb_rd           (wb_rd),
        .o_wb_rd_data      (wb_rd_data),
        .o_mem_fault       (mem_fault),
        .o_fault_addr      (fault_addr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one memory op, then acks on bus cycle ack_k (-1 = never); returns
    // with outputs sampled just after the transaction's closing edge.
    task automatic do_access(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [4:0] rd,
                             input int ack_k, input logic [31:0] rdata,
                             output int stall_n, output int req_n,
                             output logic [31:0] b_addr, output logic b_we,
                             output logic [3:0] b_strb, output logic [31:0] b_wdata);
        exec_rd_en = 1'b1; exec_rd = rd; exec_rd_reg = addr;
        exec_mem_op = op; exec_store_data = sdata;
        step();
        exec_rd_en = 1'b0; exec_mem_op = OP_NONE; exec_rd_reg = 32'h5555_5555;
        b_addr = dmem_addr; b_we = dmem_we; b_strb = dmem_wstrb; b_wdata = dmem_wdata;
        stall_n = 0; req_n = 0;
        for (int k = 0; k < 40 && exec_stall; k++) begin
            stall_n++;
            if (dmem_req) req_n++;
            dmem_ack = (k == ack_k);
            dmem_rdata = rdata;
            step();
            dmem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_checks++;
        if ({exec_stall, dmem_req, dmem_we, wb_rd_en, mem_fault, dmem_wstrb} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0",
                     {exec_stall, dmem_req, dmem_we, wb_rd_en, mem_fault, dmem_wstrb});
        end
        n_checks++;
        if ({dmem_addr, dmem_wdata, wb_rd_data, fault_addr, wb_rd} !== 133'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h wbd=%h faddr=%h rd=%0d required 0",
                     dmem_addr, dmem_wdata, wb_rd_data, fault_addr, wb_rd);
        end
    endtask

    task automatic test_passthrough();
        exec_rd_en = 1'b1; exec_rd = 5'd5; exec_mem_op = OP_NONE;
        for (int i = 0; i < 3; i++) begin
            exec_rd_reg = 32'h1234 + i;
            step();
            n_checks++;
            if ({wb_rd_en, wb_rd, wb_rd_data, exec_stall} !== {1'b1, 5'd5, 32'h1234 + i, 1'b0}) begin
                n_fail++;
                $display("FAIL pass_%0d: en=%b rd=%0d data=%h stall=%b required 1/5/%h/0",
                         i, wb_rd_en, wb_rd, wb_rd_data, exec_stall, 32'h1234 + i);
            end
        end
        exec_rd = 5'd0; exec_rd_reg = 32'h9999;
        step();
        n_checks++;
        if ({wb_rd_en, wb_rd, wb_rd_data} !== {1'b0, 5'd5, 32'h1236}) begin
            n_fail++;
            $display("FAIL pass_rd0: en=%b rd=%0d data=%h required 0/5/00001236",
                     wb_rd_en, wb_rd, wb_rd_data);
        end
        exec_rd_en = 1'b0;
        step();
        n_checks++;
        if (wb_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_idle: en=%b required 0", wb_rd_en);
        end
    endtask

    task automatic test_load(input string name, input logic [3:0] op, input logic [31:0] addr,
                             input int ack_k, input logic [31:0] rdata, input logic [31:0] exp);
        int sn, rn; logic [31:0] ba, bd; logic bw; logic [3:0] bs;
        do_access(op, addr, 32'h0, 5'd7, ack_k, rdata, sn, rn, ba, bw, bs, bd);
        n_checks++;
        if ({ba, bw, bs} !== {addr & 32'hFFFF_FFFC, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL %s_bus: addr=%h we=%b strb=%b required %h/0/0000",
                     name, ba, bw, bs, addr & 32'hFFFF_FFFC);
        end
        n_checks++;
        if (sn !== ack_k + 1) begin
            n_fail++;
            $display("FAIL %s_stall: got %0d cycles required %0d", name, sn, ack_k + 1);
        end
        n_checks++;
        if ({wb_rd_en, wb_rd, wb_rd_data, mem_fault, dmem_req} !== {1'b1, 5'd7, exp, 2'b00}) begin
            n_fail++;
            $display("FAIL %s_wb: en=%b rd=%0d data=%h fault=%b req=%b required 1/7/%h/0/0",
                     name, wb_rd_en, wb_rd, wb_rd_data, mem_fault, dmem_req, exp);
        end
        step();
        n_checks++;
        if (wb_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: en=%b required 0", name, wb_rd_en);
        end
    endtask

    task automatic test_store(input string name, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input int ack_k,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        int sn, rn; logic [31:0] ba, bd; logic bw; logic [3:0] bs;
        do_access(op, addr, sdata, 5'd3, ack_k, 32'hFFFF_FFFF, sn, rn, ba, bw, bs, bd);
        n_checks++;
        if ({ba, bw, bs, bd} !== {addr & 32'hFFFF_FFFC, 1'b1, exp_strb, exp_wdata}) begin
            n_fail++;
            $display("FAIL %s_bus: addr=%h we=%b strb=%b wdata=%h required %h/1/%b/%h",
                     name, ba, bw, bs, bd, addr & 32'hFFFF_FFFC, exp_strb, exp_wdata);
        end
        n_checks++;
        if ({sn, wb_rd_en, dmem_req, exec_stall} !== {ack_k + 1, 3'b000}) begin
            n_fail++;
            $display("FAIL %s_done: stall_n=%0d wb=%b req=%b stall=%b required %0d/0/0/0",
                     name, sn, wb_rd_en, dmem_req, exec_stall, ack_k + 1);
        end
    endtask

    task automatic test_misaligned();
        exec_rd_en = 1'b1; exec_rd = 5'd4; exec_rd_reg = 32'h301; exec_mem_op = OP_LW;
        step();
        exec_rd_en = 1'b0; exec_mem_op = OP_NONE;
        n_checks++;
        if ({dmem_req, exec_stall, wb_rd_en, mem_fault, fault_addr} !== {4'b0001, 32'h301}) begin
            n_fail++;
            $display("FAIL misalign: req=%b stall=%b wb=%b fault=%b faddr=%h required 0/0/0/1/301",
                     dmem_req, exec_stall, wb_rd_en, mem_fault, fault_addr);
        end
        step();
        n_checks++;
        if ({mem_fault, fault_addr} !== {1'b0, 32'h301}) begin
            n_fail++;
            $display("FAIL misalign_hold: fault=%b faddr=%h required 0/301", mem_fault, fault_addr);
        end
    endtask

    task automatic test_timeout();
        int sn, rn; logic [31:0] ba, bd; logic bw; logic [3:0] bs;
        do_access(OP_LW, 32'h400, 32'h0, 5'd9, -1, 32'h0, sn, rn, ba, bw, bs, bd);
        n_checks++;
        if ({sn, rn} !== {32'd16, 32'd16}) begin
            n_fail++;
            $display("FAIL timeout_len: stall=%0d req=%0d required 16/16", sn, rn);
        end
        n_checks++;
        if ({mem_fault, fault_addr, wb_rd_en, dmem_req, exec_stall} !== {1'b1, 32'h400, 3'b000}) begin
            n_fail++;
            $display("FAIL timeout_fault: fault=%b faddr=%h wb=%b req=%b stall=%b required 1/400/0/0/0",
                     mem_fault, fault_addr, wb_rd_en, dmem_req, exec_stall);
        end
        do_access(OP_LW, 32'h404, 32'h0, 5'd9, 15, 32'h1122_3344, sn, rn, ba, bw, bs, bd);
        n_checks++;
        if ({sn, mem_fault, wb_rd_en, wb_rd_data} !== {32'd16, 2'b01, 32'h1122_3344}) begin
            n_fail++;
            $display("FAIL timeout_ackwins: stall=%0d fault=%b wb=%b data=%h required 16/0/1/11223344",
                     sn, mem_fault, wb_rd_en, wb_rd_data);
        end
    endtask

    task automatic test_reset_busy();
        exec_rd_en = 1'b1; exec_rd = 5'd11; exec_rd_reg = 32'h700; exec_mem_op = OP_LW;
        step();
        exec_rd_en = 1'b0; exec_mem_op = OP_NONE;
        step();
        n_checks++;
        if ({dmem_req, exec_stall} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstbusy_pre: req=%b stall=%b required 1/1", dmem_req, exec_stall);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({dmem_req, exec_stall, wb_rd_en, mem_fault} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstbusy_drop: req=%b stall=%b wb=%b fault=%b required 0000",
                     dmem_req, exec_stall, wb_rd_en, mem_fault);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        step();
        dmem_ack = 1'b0;
        n_checks++;
        if ({dmem_req, exec_stall, wb_rd_en, mem_fault} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstbusy_lateack: req=%b stall=%b wb=%b fault=%b required 0000",
                     dmem_req, exec_stall, wb_rd_en, mem_fault);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load("lb",  OP_LB,  32'h103, 2, 32'h80FF_1122, 32'hFFFF_FF80);
        test_load("lbu", OP_LBU, 32'h103, 2, 32'h80FF_1122, 32'h0000_0080);
        test_load("lh",  OP_LH,  32'h602, 0, 32'h8765_4321, 32'hFFFF_8765);
        test_load("lhu", OP_LHU, 32'h602, 1, 32'h8765_4321, 32'h0000_8765);
        test_store("sh", OP_SH, 32'h202, 32'hDEAD_BEEF, 1, 4'b1100, 32'hBEEF_BEEF);
        test_store("sb", OP_SB, 32'h501, 32'h1234_56AB, 0, 4'b0010, 32'hABAB_ABAB);
        test_misaligned();
        test_timeout();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nnrv_mem.md
Name: nnrv_mem

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute result (rd_en, rd, ALU result/effective address) plus a memory-op code and store data.
- Performs byte/half/word loads and stores over a req/ack data bus. Passes non-memory results through, and presents a registered write-back packet to the register-file stage.
- Stalls upstream while a bus transaction is outstanding; raises a fault on misalignment or bus timeout.

Parameters:
- XLEN, 32, datapath and address width
- TIMEOUT_CYCLES, 16, max cycles req may stay high without ack before fault (>=2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_exec_rd_en  in  1  execute result valid / destination write requested
- i_exec_rd  in  5  destination register index
- i_exec_rd_reg  in  XLEN  ALU result; effective address for memory ops
- i_exec_mem_op  in  4  NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; other codes treated as NONE
- i_exec_store_data  in  XLEN  rs2 value for stores
- o_exec_stall  out  1  upstream holds its outputs while high
- o_dmem_req  out  1  bus request
- o_dmem_we  out  1  1=store
- o_dmem_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
- o_dmem_wdata  out  XLEN  lane-replicated store data
- o_dmem_wstrb  out  4  byte enables
- i_dmem_ack  in  1  single-cycle completion
- i_dmem_rdata  in  XLEN  load word, valid with ack
- o_wb_rd_en  out  1  write-back valid
- o_wb_rd  out  5  write-back register
- o_wb_rd_data  out  XLEN  write-back value
- o_mem_fault  out  1  one-cycle fault pulse
- o_fault_addr  out  XLEN  byte address of faulting access, held until next fault

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0. Reset mid-transaction drops req at that edge; the pending access is discarded and produces no write-back.
- All outputs are registered; o_exec_stall = (state==BUSY).
- IDLE, mem_op NONE:
  - Next cycle: wb_rd_en = i_exec_rd_en && rd!=0; wb_rd = rd; wb_rd_data = i_exec_rd_reg.
  - Latency is 1 cycle and throughput is 1 per cycle.
- IDLE, memory op, misaligned (LH/LHU/SH with addr[0]; LW/SW with addr[1:0]!=0):
  - No bus access; wb_rd_en = 0.
  - o_mem_fault pulses next cycle; o_fault_addr = addr.
  - State stays IDLE.
- IDLE, aligned memory op:
  - Latch rd, rd_en, op, addr[1:0].
  - Next cycle: req=1, we, addr, wdata, wstrb driven; wb_rd_en=0; counter=0; go BUSY.
- Store lanes:
  - SB: wstrb = 1<<addr[1:0], wdata = byte replicated x4.
  - SH: wstrb = 0011 or 1100, wdata = half replicated x2.
  - SW: wstrb = 1111.
  - Loads drive wstrb = 0000 and we = 0.
- BUSY:
  - req and all bus outputs held stable; inputs from execute ignored (upstream holds).
  - Counter increments each cycle.
- ack in BUSY:
  - Next cycle: req=0, state IDLE, stall=0.
  - Load: wb_rd_en = latched rd_en && rd!=0; wb_rd_data = selected byte/half from rdata by addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - Store: wb_rd_en = 0.
- Timeout: counter reaching TIMEOUT_CYCLES-1 without ack:
  - Next cycle: req=0, fault pulse, fault_addr = latched byte address, no write-back, state IDLE.
  - If ack arrives in the same cycle as the timeout, ack wins.
- Latency of an aligned load with ack in bus cycle k (the first req cycle is k=0): wb valid at cycle k+1 after the req started; stall high for k+1 cycles.
- o_wb_rd_en is a one-cycle pulse per retired result; wb_rd and wb_rd_data hold their last values when it is low.

Decomposition:
- Package nnrv_pkg: MEM_OP_* codes, FSM state encoding (IDLE, BUSY), wstrb constants.
- Sub-module nnrv_load_align: combinational; inputs rdata, addr[1:0], op; output extended XLEN value.
- Lane/strobe generation and the FSM stay in nnrv_mem.

Test Plan:
- ALU pass-through: rd_en=1, rd=5, rd_reg=0x1234, op NONE for 3 consecutive cycles -> wb pulse each following cycle with data 0x1234, stall never high; rd=0 -> wb_rd_en=0.
- LB sign-extend: addr=0x103, rdata=0x80FF_1122 with ack on 3rd req cycle -> dmem_addr=0x100, wstrb=0, stall high 3 cycles, wb_rd_data=0xFFFF_FF80; same with LBU -> 0x0000_0080.
- SH upper half: addr=0x202, data=0xDEAD_BEEF, ack after 1 cycle -> we=1, wstrb=1100, wdata=0xBEEF_BEEF, no wb pulse.
- Misaligned LW: addr=0x301 -> no req, fault pulse next cycle, fault_addr=0x301, wb_rd_en=0.
- Timeout: LW addr=0x400, ack never -> req high exactly 16 cycles then drops, fault pulse, fault_addr=0x400, stall deasserts; ack on cycle 16 instead -> normal write-back, no fault.
- Reset mid-BUSY: i_rst asserted on 2nd req cycle -> next cycle req=0, stall=0, wb_rd_en=0, fault=0; a late ack is ignored.
